// File: rtl/attention_stream_host.sv
// Host-side sequencer for an N x N attention array.
//
// Collects a row-major stream of 3*N*N operand elements into the Q, K and V
// buffers, fires the array with a one-cycle valid_input pulse (held off until
// the array's post-reset warm-up has elapsed), waits for the array's
// valid_result with a bounded timeout, captures the result matrix, and
// replays it row-major on a valid/ready output stream.
//
// Elements are opaque DataWidth-bit words. With the default width of 64 they
// carry IEEE-754 doubles, so an all-zero word is 0.0.
//
// Ports:
//   clk                 single clock, rising edge
//   reset               asynchronous, active-low reset
//   in_valid/in_ready   load-stream handshake; in_data is the element
//   Q/K/V_matrix        operand buffers driven to the array, [row][col]
//   valid_input         one-cycle start pulse to the array
//   valid_result        array completion pulse; attention is its result
//   out_valid/out_ready result-stream handshake; out_data is the element
//   out_last            marks element (N-1, N-1)
//   busy                high while firing, waiting or draining
//   timeout_err         sticky; set when the array never answered
module attention_stream_host #(
   parameter int unsigned N         = 4,
   parameter int unsigned WARMUP    = 4,
   parameter int unsigned TIMEOUT   = 256,
   parameter int unsigned DataWidth = 64
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [DataWidth-1:0]                in_data,
   output logic [0:N-1][0:N-1][DataWidth-1:0]  Q_matrix,
   output logic [0:N-1][0:N-1][DataWidth-1:0]  K_matrix,
   output logic [0:N-1][0:N-1][DataWidth-1:0]  V_matrix,
   output logic                                valid_input,
   input  logic                                valid_result,
   input  logic [0:N-1][0:N-1][DataWidth-1:0]  attention,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [DataWidth-1:0]                out_data,
   output logic                                out_last,
   output logic                                busy,
   output logic                                timeout_err
);

   localparam int unsigned NN      = N * N;
   localparam int unsigned LoadCnt = 3 * NN;
   localparam int unsigned LW      = (LoadCnt > 1) ? $clog2(LoadCnt) : 1;
   localparam int unsigned EW      = (NN > 1) ? $clog2(NN) : 1;
   localparam int unsigned TW      = $clog2(TIMEOUT + 1);
   localparam int unsigned WW      = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

   localparam logic [LW-1:0] LastLoad = LW'(LoadCnt - 1);
   localparam logic [LW-1:0] KBase    = LW'(NN);
   localparam logic [LW-1:0] VBase    = LW'(2 * NN);
   localparam logic [EW-1:0] LastElem = EW'(NN - 1);
   localparam logic [TW-1:0] LastTick = TW'(TIMEOUT - 1);
   localparam logic [WW-1:0] WarmDone = WW'(WARMUP);

   typedef enum logic [1:0] {
      StLoad,
      StFire,
      StWait,
      StDrain
   } state_e;

   state_e state_q;

   // Buffers are kept flat; [0:NN-1] has the same row-major bit layout as
   // [0:N-1][0:N-1], so they map straight onto the matrix ports.
   logic [0:NN-1][DataWidth-1:0] q_q, k_q, v_q, res_q;

   logic [LW-1:0]        load_idx_q;
   logic [EW-1:0]        out_idx_q;
   logic [TW-1:0]        timer_q;
   logic [WW-1:0]        warm_q;
   logic                 in_ready_q;
   logic                 valid_input_q;
   logic                 out_valid_q;
   logic [DataWidth-1:0] out_data_q;
   logic                 out_last_q;
   logic                 busy_q;
   logic                 timeout_err_q;

   logic [WW-1:0] warm_d;
   logic          fire_ok;
   logic [1:0]    load_sel;
   logic [EW-1:0] load_off;
   logic [EW-1:0] out_idx_nxt;

   // Warm-up counter saturates; the array may be fired in any cycle where
   // the counter has reached WARMUP, so look at the post-edge value.
   always_comb begin
      warm_d  = (warm_q == WarmDone) ? warm_q : warm_q + WW'(1);
      fire_ok = (warm_d == WarmDone);
   end

   // Split the global load index into buffer select and element offset.
   always_comb begin
      load_sel = 2'd0;
      load_off = '0;
      if (load_idx_q < KBase) begin
         load_sel = 2'd0;
         load_off = EW'(load_idx_q);
      end else if (load_idx_q < VBase) begin
         load_sel = 2'd1;
         load_off = EW'(load_idx_q - KBase);
      end else begin
         load_sel = 2'd2;
         load_off = EW'(load_idx_q - VBase);
      end
   end

   always_comb begin
      out_idx_nxt = out_idx_q + EW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StLoad;
         q_q           <= '0;
         k_q           <= '0;
         v_q           <= '0;
         res_q         <= '0;
         load_idx_q    <= '0;
         out_idx_q     <= '0;
         timer_q       <= '0;
         warm_q        <= '0;
         in_ready_q    <= 1'b0;
         valid_input_q <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_last_q    <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         warm_q <= warm_d;
         unique case (state_q)
            StLoad: begin
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  if (load_sel == 2'd0) begin
                     q_q[load_off] <= in_data;
                  end else if (load_sel == 2'd1) begin
                     k_q[load_off] <= in_data;
                  end else begin
                     v_q[load_off] <= in_data;
                  end
                  if (load_idx_q == LastLoad) begin
                     // Fire in the very next cycle if warm-up is already done.
                     load_idx_q    <= '0;
                     in_ready_q    <= 1'b0;
                     valid_input_q <= fire_ok;
                     busy_q        <= 1'b1;
                     state_q       <= StFire;
                  end else begin
                     load_idx_q <= load_idx_q + LW'(1);
                  end
               end
            end

            StFire: begin
               if (valid_input_q) begin
                  valid_input_q <= 1'b0;
                  state_q       <= StWait;
               end else if (fire_ok) begin
                  valid_input_q <= 1'b1;
               end
            end

            StWait: begin
               if (valid_result) begin
                  res_q       <= attention;
                  timer_q     <= '0;
                  out_idx_q   <= '0;
                  out_valid_q <= 1'b1;
                  out_data_q  <= attention[0][0];
                  out_last_q  <= (NN == 1);
                  state_q     <= StDrain;
               end else if (timer_q == LastTick) begin
                  timer_q       <= '0;
                  timeout_err_q <= 1'b1;
                  busy_q        <= 1'b0;
                  in_ready_q    <= 1'b1;
                  state_q       <= StLoad;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end

            StDrain: begin
               if (out_valid_q && out_ready) begin
                  if (out_last_q) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     out_idx_q   <= '0;
                     busy_q      <= 1'b0;
                     in_ready_q  <= 1'b1;
                     state_q     <= StLoad;
                  end else begin
                     out_idx_q  <= out_idx_nxt;
                     out_data_q <= res_q[out_idx_nxt];
                     out_last_q <= (out_idx_nxt == LastElem);
                  end
               end
            end

            default: begin
               state_q <= StLoad;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign Q_matrix    = q_q;
   assign K_matrix    = k_q;
   assign V_matrix    = v_q;
   assign valid_input = valid_input_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_last    = out_last_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

endmodule
